pulse_generator: RTL and testbench
==================================

Name: pulse_generator

Overview:
Transmit-side companion to the pulse detection/counting block: emits a programmed number of clean, registered pulses on o_pulse with programmable high and low widths.
Used to drive a pulse counter input in the same clock domain, either in a loopback self-test or as a stimulus source.
Software/top-level loads a count and widths, issues a start strobe, and receives busy/done status plus a running sent-count.

Parameters:
CNT_W, 16, width of pulse-number and sent-count; matches counter width 16.
WID_W, 8, width of high/low period fields, in clock cycles.

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_rst_n  input  1  reset; synchronous, active-low.
i_start  input  1  one-cycle start strobe; honoured only in IDLE.
i_abort  input  1  stop the burst immediately; any state.
i_pulse_num  input  CNT_W  number of pulses to send; sampled at accepted start.
i_high_cyc  input  WID_W  high width in cycles; 0 treated as 1.
i_low_cyc  input  WID_W  low gap in cycles after every pulse; 0 treated as 1.
o_pulse  output  1  generated pulse train, driven directly from a flop.
o_busy  output  1  high from accepted start until return to IDLE.
o_done  output  1  one-cycle strobe when a burst completes normally.
o_pulse_sent  output  CNT_W  pulses fully emitted in the current or last burst.

Behaviour:
- Reset (i_rst_n=0 at an edge): state IDLE; o_pulse=0, o_busy=0, o_done=0, o_pulse_sent=0; internal latches cleared.
- Reset mid-burst obeys the same rules: all outputs return to their reset values at the next edge.
- FSM states: IDLE, HIGH, LOW, FIN.

IDLE:
- Accept i_start only when i_abort=0.
- On accept: latch num/high/low (0 widths become 1), clear o_pulse_sent, set o_busy.
- If num≠0: go to HIGH, o_pulse=1 at the same edge. Latency is 1 clock from the start edge to o_pulse rising.
- If num=0: go to FIN; no pulse is emitted.

HIGH:
- o_pulse=1 for exactly high_cyc cycles, tracked by a width counter.
- On the last cycle: go to LOW, drive o_pulse=0, and increment o_pulse_sent.

LOW:
- o_pulse=0 for exactly low_cyc cycles, including after the final pulse. This guarantees a low level that a 2-flop edge detector will see.
- At the end of LOW: if o_pulse_sent==num, go to FIN; otherwise go to HIGH with o_pulse=1.

FIN:
- One cycle long: o_done=1, o_busy=0 at the next edge, then return to IDLE.
- o_pulse_sent holds its value until the next accepted start.

Timing and edge cases:
- Pulse period is high_cyc+low_cyc cycles. A burst from the start edge to o_done takes num*(H+L)+1 cycles.
- i_abort=1 in any non-IDLE state: next edge goes to IDLE with o_pulse=0, o_busy=0. No o_done; o_pulse_sent keeps the number of fully completed pulses.
- i_abort has priority over i_start and over all transitions.
- i_start while busy is ignored, not queued. Input changes while busy are ignored because config is latched.
- num=0xFFFF must complete without counter wrap. o_pulse_sent is CNT_W bits and the compare is equality, so no wrap occurs.
- Width counters count down from the latched value to 1. There is no overflow for widths up to 2^WID_W-1.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, HIGH=2'd1, LOW=2'd2, FIN=2'd3) and the default CNT_W/WID_W constants, also used by the counter side.
- Natural sub-module: pulse_width_timer. It is a loadable down-counter with load value, enable and an expired flag, and it is instantiated once and reloaded per phase.
- A loopback top (generator into pulse_counter) belongs to the bench, not this block.

Test Plan:
1. Reset held 3 cycles, then released with no start -> o_pulse=0, o_busy=0, o_done=0, o_pulse_sent=0 throughout.
2. num=5, H=2, L=3, start -> o_pulse rises 1 clock after start and follows a 2-high/3-low pattern five times. o_done fires 26 cycles after the start edge; o_pulse_sent=5. A looped-back pulse_counter with en=1 reads 5.
3. num=3, H=0, L=0 -> treated as 1/1: alternating 1,0 for 6 cycles; o_done after 7 cycles; o_pulse_sent=3.
4. num=0, start -> no pulse; o_done one cycle after the start edge is sampled; o_busy high for only that one cycle; o_pulse_sent=0.
5. num=10, H=4, L=4; abort during the HIGH phase of pulse 4 -> o_pulse=0 the next cycle, IDLE, no o_done, o_pulse_sent=3. A new start is then accepted normally.
6. Start re-pulsed mid-burst with different config -> ignored; the burst finishes with the original num/H/L. Synchronous reset asserted mid-LOW -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/pulse_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_generator_pkg
// Description : Shared FSM state encodings and default widths for the pulse
//               generator and its companion pulse counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_generator_pkg;

    localparam int unsigned c_def_cnt_w = 16;
    localparam int unsigned c_def_wid_w = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_FIN  = 2'd3
    } pg_state_e;

endpackage : pulse_generator_pkg
`default_nettype wire

// File: rtl/pulse_generator_timer.sv
`default_nettype none
// ============================================================================
// Module      : pulse_width_timer
// Description : Loadable down-counter; flags expiry on the last cycle of a phase.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_width_timer
    import pulse_generator_pkg::*;
#(
    parameter int unsigned WID_W = c_def_wid_w
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WID_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [WID_W-1:0] cnt_q;
    logic [WID_W-1:0] cnt_d;

    // Counts down to 1 and parks there; a load always wins over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_en && (cnt_q > WID_W'(1))) begin
            cnt_d = cnt_q - WID_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q <= WID_W'(1));

endmodule : pulse_width_timer
`default_nettype wire

// File: rtl/pulse_generator.sv
`default_nettype none
// ============================================================================
// Module      : pulse_generator
// Description : Emits a programmed burst of registered pulses with
//               programmable high/low widths, plus busy/done/sent status.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_generator
    import pulse_generator_pkg::*;
#(
    parameter int unsigned CNT_W = c_def_cnt_w,
    parameter int unsigned WID_W = c_def_wid_w
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_pulse_num,
    input  logic [WID_W-1:0] i_high_cyc,
    input  logic [WID_W-1:0] i_low_cyc,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_pulse_sent
);

    pg_state_e        state_q, state_d;
    logic             pulse_q, pulse_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [CNT_W-1:0] sent_q,  sent_d;
    logic [CNT_W-1:0] num_q,   num_d;
    logic [WID_W-1:0] high_q,  high_d;
    logic [WID_W-1:0] low_q,   low_d;

    logic [WID_W-1:0] w_high_eff;
    logic [WID_W-1:0] w_low_eff;
    logic             w_tmr_load;
    logic [WID_W-1:0] w_tmr_load_val;
    logic             w_tmr_en;
    logic             w_tmr_expired;

    // A zero width would give a phase of no length; treat it as one cycle.
    assign w_high_eff = (i_high_cyc == '0) ? WID_W'(1) : i_high_cyc;
    assign w_low_eff  = (i_low_cyc  == '0) ? WID_W'(1) : i_low_cyc;

    always_comb begin
        state_d        = state_q;
        pulse_d        = pulse_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        sent_d         = sent_q;
        num_d          = num_q;
        high_d         = high_q;
        low_d          = low_q;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = high_q;
        w_tmr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    num_d  = i_pulse_num;
                    high_d = w_high_eff;
                    low_d  = w_low_eff;
                    sent_d = '0;
                    busy_d = 1'b1;
                    if (i_pulse_num != '0) begin
                        state_d        = ST_HIGH;
                        pulse_d        = 1'b1;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = w_high_eff;
                    end else begin
                        state_d = ST_FIN;
                        pulse_d = 1'b0;
                    end
                end
            end

            ST_HIGH: begin
                w_tmr_en = 1'b1;
                if (w_tmr_expired) begin
                    state_d        = ST_LOW;
                    pulse_d        = 1'b0;
                    sent_d         = sent_q + CNT_W'(1);
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = low_q;
                end
            end

            ST_LOW: begin
                w_tmr_en = 1'b1;
                if (w_tmr_expired) begin
                    // Equality compare: a full-scale count never wraps.
                    if (sent_q == num_q) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d        = ST_HIGH;
                        pulse_d        = 1'b1;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = high_q;
                    end
                end
            end

            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides every transition; completed-pulse count is kept.
        if (i_abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            pulse_d    = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            sent_d     = sent_q;
            w_tmr_load = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sent_q  <= '0;
            num_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sent_q  <= sent_d;
            num_q   <= num_d;
            high_q  <= high_d;
            low_q   <= low_d;
        end
    end

    pulse_width_timer #(
        .WID_W (WID_W)
    ) u_width_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_en       (w_tmr_en),
        .o_expired  (w_tmr_expired)
    );

    assign o_pulse      = pulse_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_pulse_sent = sent_q;

endmodule : pulse_generator
`default_nettype wire

// File: tb/tb_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_generator
// Description : Self-checking bench: burst-level reference model checked every
//               cycle, directed burst table, hand sequences, random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_generator;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned WID_W = 8;

    logic             clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic [CNT_W-1:0] i_pulse_num = '0;
    logic [WID_W-1:0] i_high_cyc = '0;
    logic [WID_W-1:0] i_low_cyc = '0;
    logic             o_pulse;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_pulse_sent;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pulse_generator #(
        .CNT_W (CNT_W),
        .WID_W (WID_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_pulse_num  (i_pulse_num),
        .i_high_cyc   (i_high_cyc),
        .i_low_cyc    (i_low_cyc),
        .o_pulse      (o_pulse),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pulse_sent (o_pulse_sent)
    );

    // Burst-level reference: k counts edges since the accepted start edge.
    bit m_act = 1'b0;
    int m_k, m_n, m_h, m_l;
    int e_pulse = 0, e_busy = 0, e_done = 0, e_sent = 0;

    function automatic int sent_at(int k);
        int s;
        if (k < m_h) return 0;
        s = (k - m_h) / (m_h + m_l) + 1;
        return (s < m_n) ? s : m_n;
    endfunction

    task automatic model_step();
        int p, t;
        if (!i_rst_n) begin
            m_act = 1'b0;
            e_pulse = 0; e_busy = 0; e_done = 0; e_sent = 0;
        end else if (m_act) begin
            if (i_abort) begin
                m_act = 1'b0;
                e_pulse = 0; e_busy = 0; e_done = 0;
            end else begin
                m_k++;
                p = m_h + m_l;
                t = m_n * p + 1;
                e_pulse = ((m_k < m_n * p) && ((m_k % p) < m_h)) ? 1 : 0;
                e_busy  = (m_k < t) ? 1 : 0;
                e_done  = (m_k == t) ? 1 : 0;
                e_sent  = sent_at(m_k);
                if (m_k == t) m_act = 1'b0;
            end
        end else if (i_start && !i_abort) begin
            m_act = 1'b1;
            m_k = 0;
            m_n = int'(i_pulse_num);
            m_h = (i_high_cyc == 0) ? 1 : int'(i_high_cyc);
            m_l = (i_low_cyc == 0) ? 1 : int'(i_low_cyc);
            e_pulse = (m_n != 0) ? 1 : 0;
            e_busy = 1; e_done = 0; e_sent = 0;
        end else begin
            e_pulse = 0; e_busy = 0; e_done = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("o_pulse",      32'(o_pulse),      32'(e_pulse));
        chk("o_busy",       32'(o_busy),       32'(e_busy));
        chk("o_done",       32'(o_done),       32'(e_done));
        chk("o_pulse_sent", 32'(o_pulse_sent), 32'(e_sent));
    endtask

    typedef struct {
        int num;
        int h;
        int l;
        int abort_n;    // tick index at which abort is applied, -1 for none
        int exp_done_n; // ticks after start edge to o_done, -1 for none
        int exp_end_n;  // ticks after start edge to o_busy falling
        int exp_sent;
    } vec_t;

    vec_t vecs[6];

    task automatic start_burst(input int num, input int h, input int l);
        i_pulse_num = CNT_W'(num);
        i_high_cyc  = WID_W'(h);
        i_low_cyc   = WID_W'(l);
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    initial begin
        int got_done, got_end;

        vecs[0] = '{num: 5,  h: 2,   l: 3,   abort_n: -1, exp_done_n: 26,  exp_end_n: 26,  exp_sent: 5};
        vecs[1] = '{num: 3,  h: 0,   l: 0,   abort_n: -1, exp_done_n: 7,   exp_end_n: 7,   exp_sent: 3};
        vecs[2] = '{num: 0,  h: 5,   l: 5,   abort_n: -1, exp_done_n: 1,   exp_end_n: 1,   exp_sent: 0};
        vecs[3] = '{num: 10, h: 4,   l: 4,   abort_n: 25, exp_done_n: -1,  exp_end_n: 25,  exp_sent: 3};
        vecs[4] = '{num: 1,  h: 255, l: 1,   abort_n: -1, exp_done_n: 257, exp_end_n: 257, exp_sent: 1};
        vecs[5] = '{num: 2,  h: 1,   l: 255, abort_n: -1, exp_done_n: 513, exp_end_n: 513, exp_sent: 2};

        // Reset held for three cycles, then idle with no start.
        i_rst_n = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        repeat (5) tick();

        foreach (vecs[i]) begin
            start_burst(vecs[i].num, vecs[i].h, vecs[i].l);
            got_done = -1;
            got_end  = -1;
            for (int n = 1; n <= vecs[i].exp_end_n + 20; n++) begin
                if (n == vecs[i].abort_n) i_abort = 1'b1;
                tick();
                i_abort = 1'b0;
                if (o_done && got_done < 0) got_done = n;
                if (!o_busy) begin
                    got_end = n;
                    break;
                end
            end
            chk($sformatf("vec%0d done_cycle", i), 32'(got_done), 32'(vecs[i].exp_done_n));
            chk($sformatf("vec%0d end_cycle", i),  32'(got_end),  32'(vecs[i].exp_end_n));
            chk($sformatf("vec%0d sent", i),       32'(o_pulse_sent), 32'(vecs[i].exp_sent));
            tick();
        end

        // Start re-pulsed mid-burst with another config must be ignored.
        start_burst(3, 2, 2);
        got_done = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 4) begin
                i_pulse_num = CNT_W'(9);
                i_high_cyc  = WID_W'(1);
                i_low_cyc   = WID_W'(1);
                i_start     = 1'b1;
            end
            tick();
            i_start = 1'b0;
            if (o_done) begin
                got_done = n;
                break;
            end
        end
        chk("restart_ignored done_cycle", 32'(got_done), 32'd13);
        chk("restart_ignored sent", 32'(o_pulse_sent), 32'd3);
        tick();

        // Synchronous reset in the LOW phase clears all outputs next edge.
        start_burst(4, 2, 3);
        repeat (3) tick();
        i_rst_n = 1'b0;
        tick();
        chk("rst_mid_low pulse", 32'(o_pulse), 32'd0);
        chk("rst_mid_low busy",  32'(o_busy),  32'd0);
        chk("rst_mid_low sent",  32'(o_pulse_sent), 32'd0);
        i_rst_n = 1'b1;
        tick();

        // Randomised traffic including config churn, aborts and resets.
        for (int n = 0; n < 3000; n++) begin
            i_start     = ($urandom_range(0, 7) == 0);
            i_abort     = ($urandom_range(0, 79) == 0);
            i_rst_n     = ($urandom_range(0, 299) != 0);
            i_pulse_num = CNT_W'($urandom_range(0, 6));
            i_high_cyc  = WID_W'($urandom_range(0, 5));
            i_low_cyc   = WID_W'($urandom_range(0, 5));
            tick();
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        i_rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pulse_generator
`default_nettype wire
